// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 2-channel FP16 convolution datapath: walks output positions, tracks kernel latency.
// Optional stall counter enabled by defining CONV_SEQ_CTRL_PERF_EN.
module conv_seq_ctrl #(
  parameter int DIM_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int KERNEL_LAT = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_cfg_h,
  input  logic [DIM_W-1:0]  i_cfg_w,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_wgt_load,
  output logic              o_win_req,
  output logic [DIM_W-1:0]  o_win_row,
  output logic [DIM_W-1:0]  o_win_col,
  input  logic              i_win_gnt,
  output logic              o_ofmap_valid,
  output logic [ADDR_W-1:0] o_ofmap_addr,
  output logic [31:0]       o_perf_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DIM_W-1:0]      r_oh;
  logic [DIM_W-1:0]      r_ow;
  logic [DIM_W-1:0]      r_row;
  logic [DIM_W-1:0]      r_col;
  logic [KERNEL_LAT-1:0] r_vsr;
  logic [KERNEL_LAT-1:0] w_vsr_next;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_err;
  logic                  w_cfg_bad;
  logic                  w_accept;
  logic                  w_grant;
  logic                  w_col_wrap;
  logic                  w_last_win;

  assign w_cfg_bad  = (i_cfg_h < DIM_W'(3)) || (i_cfg_w < DIM_W'(3));
  assign w_accept   = (r_state == S_IDLE) && i_start && !w_cfg_bad;
  assign w_grant    = (r_state == S_RUN) && i_win_gnt;
  assign w_col_wrap = (r_col == r_ow - DIM_W'(1));
  assign w_last_win = (r_row == r_oh - DIM_W'(1)) && w_col_wrap;
  // Drain ends as soon as the last valid leaves the pipe, so done lands one cycle after it.
  assign w_vsr_next = (r_vsr << 1) | KERNEL_LAT'(w_grant);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_wgt_load = 1'b0;
    o_win_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_WLOAD;
      end
      S_WLOAD: begin
        o_busy     = 1'b1;
        o_wgt_load = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        o_busy    = 1'b1;
        o_win_req = 1'b1;
        if (i_win_gnt && w_last_win) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_vsr_next == '0) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_oh   <= '0;
      r_ow   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_vsr  <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && i_start && w_cfg_bad;
      r_vsr <= w_vsr_next;
      if (w_accept) begin
        r_oh <= i_cfg_h - DIM_W'(2);
        r_ow <= i_cfg_w - DIM_W'(2);
      end
      if (r_state == S_WLOAD) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_grant) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
      if (r_state == S_WLOAD)  r_addr <= '0;
      else if (o_ofmap_valid)  r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign o_win_row     = o_win_req ? r_row : '0;
  assign o_win_col     = o_win_req ? r_col : '0;
  assign o_ofmap_valid = r_vsr[KERNEL_LAT-1];
  assign o_ofmap_addr  = r_addr;
  assign o_err         = r_err;

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of request cycles the fetch unit left ungranted.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                                   r_stall_cnt <= '0;
    else if (w_accept)                                           r_stall_cnt <= '0;
    else if ((r_state == S_RUN) && !i_win_gnt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_perf_stall_cnt = r_stall_cnt;
`else
  assign o_perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed jobs with patterned and random grant
// behaviour, checked every cycle against an event-timeline model of the sequencer.
module tb_conv_seq_ctrl;

   localparam int DIM_W  = 8;
   localparam int ADDR_W = 16;
   localparam int LAT    = 6;
   localparam int HIST   = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DIM_W-1:0]  cfgH;
   logic [DIM_W-1:0]  cfgW;
   logic              winGnt;
   logic              busy;
   logic              done;
   logic              err;
   logic              wgtLoad;
   logic              winReq;
   logic [DIM_W-1:0]  winRow;
   logic [DIM_W-1:0]  winCol;
   logic              ofmapValid;
   logic [ADDR_W-1:0] ofmapAddr;
   logic [31:0]       perfStallCnt;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;
   bit gntHist [0:HIST-1];

   conv_seq_ctrl #(
      .DIM_W      (DIM_W),
      .ADDR_W     (ADDR_W),
      .KERNEL_LAT (LAT)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_start          (start),
      .i_cfg_h          (cfgH),
      .i_cfg_w          (cfgW),
      .o_busy           (busy),
      .o_done           (done),
      .o_err            (err),
      .o_wgt_load       (wgtLoad),
      .o_win_req        (winReq),
      .o_win_row        (winRow),
      .o_win_col        (winCol),
      .i_win_gnt        (winGnt),
      .o_ofmap_valid    (ofmapValid),
      .o_ofmap_addr     (ofmapAddr),
      .o_perf_stall_cnt (perfStallCnt)
   );

   // Free-running clock; outputs are sampled and inputs driven on the falling edge.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cycle, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit s, input int h, input int w, input bit g);
      start  = s;
      cfgH   = DIM_W'(h);
      cfgW   = DIM_W'(w);
      winGnt = g;
   endtask

   // Everything the block drives must be quiet (reset state, or idle after a reset).
   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".busy"}, busy, 0);
      checkOutput({tag, ".done"}, done, 0);
      checkOutput({tag, ".err"}, err, 0);
      checkOutput({tag, ".wgtLoad"}, wgtLoad, 0);
      checkOutput({tag, ".winReq"}, winReq, 0);
      checkOutput({tag, ".winRow"}, winRow, 0);
      checkOutput({tag, ".winCol"}, winCol, 0);
      checkOutput({tag, ".valid"}, ofmapValid, 0);
      checkOutput({tag, ".addr"}, ofmapAddr, 0);
      checkOutput({tag, ".perf"}, perfStallCnt, 0);
   endtask

   // Start with an illegal map size: one err pulse, nothing else moves.
   task automatic tryBadCfg(input int h, input int w);
      @(negedge clk);
      checkOutput("bad.preErr", err, 0);
      applyStimulus(1, h, w, 0);
      @(negedge clk);
      checkOutput("bad.err", err, 1);
      checkOutput("bad.busy", busy, 0);
      checkOutput("bad.wgtLoad", wgtLoad, 0);
      checkOutput("bad.winReq", winReq, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("bad.errPulse", err, 0);
      checkOutput("bad.busyAfter", busy, 0);
      checkOutput("bad.wgtAfter", wgtLoad, 0);
      checkOutput("bad.reqAfter", winReq, 0);
   endtask

   // One job. Model: the job is a timeline of grants; window k sits at (k/OW, k%OW),
   // each grant re-emerges LAT cycles later as the next linear address, done follows
   // the last of them, and busy spans from the weight-load cycle up to that point.
   // mode: 0 always grant, 1 grant every other request cycle, 2 random grants.
   task automatic runJob(input int h, input int w, input int mode, input int resetAfter, input bit pokeStart);
      int  oh;
      int  ow;
      int  total;
      int  grants;
      int  valids;
      int  stalls;
      int  reqCycles;
      int  lastGrant;
      int  expPerf;
      bit  finished;
      bit  didReset;
      bit  expReq;
      bit  expValid;
      bit  expDone;
      bit  expBusy;
      bit  g;
      bit  s;
      oh        = h - 2;
      ow        = w - 2;
      total     = oh * ow;
      grants    = 0;
      valids    = 0;
      stalls    = 0;
      reqCycles = 0;
      lastGrant = -1;
      finished  = 0;
      didReset  = 0;
      $display("[TB] job %0dx%0d mode %0d resetAfter %0d poke %0d", h, w, mode, resetAfter, pokeStart);
      for (int i = 0; i < HIST; i++) gntHist[i] = 0;
      for (int c = 0; c < HIST; c++) begin
         @(negedge clk);
         cycle    = c;
         expReq   = (c >= 2) && (grants < total);
         expValid = (c >= LAT) && gntHist[c-LAT];
         expDone  = (lastGrant >= 0) && (c == lastGrant + LAT + 1);
         expBusy  = (c >= 1) && ((lastGrant < 0) || (c <= lastGrant + LAT));
         checkOutput("busy", busy, expBusy);
         checkOutput("wgtLoad", wgtLoad, c == 1);
         checkOutput("winReq", winReq, expReq);
         checkOutput("done", done, expDone);
         checkOutput("valid", ofmapValid, expValid);
         checkOutput("err", err, 0);
         if (expReq) begin
            checkOutput("winRow", winRow, grants / ow);
            checkOutput("winCol", winCol, grants % ow);
         end
         if (expValid) begin
            checkOutput("addr", ofmapAddr, valids);
            valids++;
         end
         if ((lastGrant >= 0) && (c == lastGrant + LAT + 4)) begin
`ifdef CONV_SEQ_CTRL_PERF_EN
            expPerf = stalls;
`else
            expPerf = 0;
`endif
            checkOutput("perfStall", perfStallCnt, expPerf);
            checkOutput("validCount", valids, total);
            finished = 1;
            break;
         end
         if ((resetAfter > 0) && (grants == resetAfter)) begin
            applyStimulus(0, 0, 0, 0);
            rst      = 1'b1;
            didReset = 1;
            finished = 1;
            break;
         end
         g = 0;
         if (expReq) begin
            case (mode)
               0:       g = 1;
               1:       g = (reqCycles % 2 == 0);
               default: g = ($urandom_range(0, 3) != 0);
            endcase
            reqCycles++;
            if (g) begin
               gntHist[c] = 1;
               grants++;
               if (grants == total) lastGrant = c;
            end else begin
               stalls++;
            end
         end
         s = (c == 0) || (pokeStart && ((c == 5) || ((lastGrant >= 0) && (c == lastGrant + LAT + 1))));
         applyStimulus(s, (c == 0) ? h : 3, (c == 0) ? w : 3, g);
      end
      checkOutput("jobCompleted", finished, 1);
      if (didReset) begin
         @(negedge clk);
         checkAllZero("midReset");
         rst = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("postReset.valid", ofmapValid, 0);
            checkOutput("postReset.done", done, 0);
            checkOutput("postReset.busy", busy, 0);
         end
      end
   endtask

   initial begin
      int rh;
      int rw;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

      runJob(5, 5, 0, 0, 0);
      runJob(4, 6, 1, 0, 0);
      tryBadCfg(2, 9);
      tryBadCfg(9, 0);
      runJob(3, 3, 0, 0, 0);
      runJob(6, 6, 0, 5, 0);
      runJob(3, 3, 0, 0, 0);
      runJob(8, 8, 2, 0, 1);
      for (int k = 0; k < 2; k++) begin
         rh = $urandom_range(3, 7);
         rw = $urandom_range(3, 7);
         runJob(rh, rw, 2, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the 3x3, 2-channel FP16 convolution kernel datapath.
- Walks every valid output position of a feature map (stride 1, no padding) in row-major order.
- Requests each 3x3 window pair from the window-fetch unit and pulses weight load at job start.
- Tracks the fixed kernel pipeline latency with a valid shift register, then emits ofmap write strobes with linear output addresses.
- Sits between the layer controller (start/done) and the kernel + ofmap SRAM.

Parameters:
DIM_W, 8, width of feature-map dimension config and row/col counters
ADDR_W, 16, width of ofmap output address
KERNEL_LAT, 6, cycles from window grant to valid kernel ofmap (multiplier register + adder tree + final add); must be >= 1

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  job start pulse; sampled only in IDLE
cfg_h  input  DIM_W  input map height; sampled on accepted start
cfg_w  input  DIM_W  input map width; sampled on accepted start
busy  output  1  job in progress
done  output  1  one-cycle job completion pulse
err  output  1  one-cycle pulse: start rejected, bad config
wgt_load  output  1  one-cycle pulse: weight registers latch new 3x3 sets
win_req  output  1  window request to fetch unit
win_row  output  DIM_W  top-left row of requested window
win_col  output  DIM_W  top-left col of requested window
win_gnt  input  1  fetch accepts; kernel inputs valid this cycle
ofmap_valid  output  1  ofmap data from kernel valid this cycle
ofmap_addr  output  ADDR_W  linear output address (row*OW+col)
perf_stall_cnt  output  32  stall counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; row/col/address counters 0; shift register 0.
- Reset mid-job: on the next edge the FSM returns to IDLE, in-flight valids are dropped (shift register cleared) and no done is emitted.
- OH = cfg_h-2, OW = cfg_w-2, latched at start.
- start in IDLE with cfg_h<3 or cfg_w<3: err=1 for one cycle; FSM stays IDLE; busy stays 0.
- start outside IDLE: ignored.
- FSM states:
  - IDLE: valid start -> WLOAD.
  - WLOAD: 1 cycle; wgt_load=1; row=col=0 -> RUN.
  - RUN:
    - win_req=1, win_row=row, win_col=col.
    - On win_gnt: col++. If col==OW-1, col=0 and row++.
    - Grant of (OH-1, OW-1) -> DRAIN.
    - win_req and win_row/win_col must hold stable while win_gnt=0.
  - DRAIN: win_req=0; stays until the shift register is all zero -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE. A start in this cycle is ignored.
- busy=1 in WLOAD, RUN and DRAIN; busy=0 in IDLE and DONE.
- Valid tracking:
  - KERNEL_LAT-bit shift register; bit0 loads (win_req & win_gnt).
  - ofmap_valid = top bit, i.e. a grant at cycle t gives ofmap_valid at t+KERNEL_LAT exactly.
  - The kernel has no stall, so grant gaps propagate as ofmap_valid gaps.
- ofmap_addr:
  - Clears to 0 in WLOAD.
  - Presents the current address while ofmap_valid=1 and increments after each ofmap_valid cycle.
  - Total ofmap_valid count per job = OH*OW.
  - The counter wraps modulo 2^ADDR_W; no overflow flag.
- done asserts exactly 1 cycle after the last ofmap_valid.

Optional Feature:
Macro CONV_SEQ_CTRL_PERF_EN.
- Defined: perf_stall_cnt counts cycles in RUN with win_req=1 and win_gnt=0.
  - Cleared on rst and on accepted start.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after the job ends.
- Not defined: perf_stall_cnt tied to 0; no counter logic.

Test Plan:
- rst, cfg 5x5, start, win_gnt always 1 -> 1-cycle wgt_load; 9 windows requested (0,0),(0,1),(0,2),(1,0)..(2,2); ofmap_valid high for 9 consecutive cycles starting KERNEL_LAT cycles after the first grant, addrs 0..8; done 1 cycle after the last valid; busy low at done.
- cfg 4x6, win_gnt low on every 2nd request cycle -> 8 outputs, addrs 0..7 in order; ofmap_valid pattern equals the grant pattern delayed by KERNEL_LAT; win_row/win_col stable during stalls; with CONV_SEQ_CTRL_PERF_EN, perf_stall_cnt=7 (stalls between 8 grants).
- start with cfg 2x9, then with cfg 9x0 -> err pulse each time, busy/win_req/wgt_load stay 0, FSM remains IDLE.
- cfg 3x3 (single window) -> exactly one grant, one ofmap_valid at addr 0, done KERNEL_LAT+1 cycles after the grant.
- cfg 6x6, assert rst after 5 grants -> next cycle all outputs 0, no further ofmap_valid, no done; new start with 3x3 completes normally with addr 0.
- start asserted during RUN and in the DONE cycle of an 8x8 job -> ignored; job produces exactly 36 outputs; single done.
